tanh_share_arbiter: RTL

Round-robin scheduler that time-shares one shift-based tanh activation unit among N_REQ requesters, such as LSTM gate lanes. It accepts one operand per cycle from the granted requester, drives it into the unit and tracks requester tags through the unit's fixed latency. It returns each result to its originating requester through a credit-guarded result FIFO, so a stalled consumer never loses results.

---
 rtl/tanh_share_pkg.sv | 23 ++
 rtl/tanh_share_arbiter_if.sv | 23 ++
 rtl/tanh_share_arbiter_fifo.sv | 64 ++++++
 rtl/tanh_share_arbiter.sv | 116 +++++++++++
 4 files changed

// File: rtl/tanh_share_pkg.sv
// Shared types and helpers for the tanh time-sharing arbiter.
package tanh_share_pkg;

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   // Widest requester tag that is supported (N_REQ up to 8).
   localparam int unsigned IdMaxW = 3;

   typedef logic [IdMaxW-1:0] id_t;

   typedef struct packed {
      logic valid;
      id_t  id;
   } tag_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < value) w++;
      return w;
   endfunction

endpackage

// File: rtl/tanh_share_arbiter_if.sv
// Requester-side operand and result handshake bundle.
interface tanh_share_arbiter_if #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned W_IN  = 16,
   parameter int unsigned W_OUT = 16
);
   logic [N_REQ-1:0]      req_valid;
   logic [N_REQ-1:0]      req_ready;
   logic [N_REQ*W_IN-1:0] req_data;
   logic [N_REQ-1:0]      rsp_valid;
   logic [N_REQ-1:0]      rsp_ready;
   logic [W_OUT-1:0]      rsp_data;

   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/tanh_share_arbiter_fifo.sv
// In-order result buffer: circular storage with simultaneous push/pop.
module act_result_fifo
   import tanh_share_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned W_OUT = 16,
   parameter int unsigned ID_W  = 3,
   localparam int unsigned PTR_W = clog2(DEPTH),
   localparam int unsigned CNT_W = clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [ID_W-1:0]  push_id_i,
   input  logic [W_OUT-1:0] push_data_i,
   input  logic             pop_i,
   output logic [ID_W-1:0]  head_id_o,
   output logic [W_OUT-1:0] head_data_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);
   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [W_OUT-1:0] data;
   } entry_t;

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             pop_en;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      pop_en   = pop_i && (count_q != '0);
      wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      if (push_i && !pop_en) count_d = count_q + 1'b1;
      if (!push_i && pop_en) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int k = 0; k < int'(DEPTH); k++) mem_q[k] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push_i) mem_q[wr_ptr_q] <= '{id: push_id_i, data: push_data_i};
      end
   end

   assign head_id_o   = mem_q[rd_ptr_q].id;
   assign head_data_o = mem_q[rd_ptr_q].data;
   assign empty_o     = (count_q == '0);
   assign count_o     = count_q;

endmodule

// File: rtl/tanh_share_arbiter.sv
// Round-robin time-sharing of one fixed-latency tanh unit among N_REQ requesters,
// with tag tracking and a credit-guarded in-order result FIFO.
module tanh_share_arbiter
   import tanh_share_pkg::*;
#(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned W_IN        = 16,
   parameter int unsigned W_OUT       = 16,
   parameter int unsigned ACT_LATENCY = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 enable_i,
   tanh_share_arbiter_if.slave  bus_io,
   output logic [W_IN-1:0]      act_in_o,
   input  logic [W_OUT-1:0]     act_out_i,
   output logic                 busy_o
);
   localparam int unsigned ID_W  = clog2(N_REQ);
   localparam int unsigned DEPTH = ACT_LATENCY + 1;
   localparam int unsigned CNT_W = clog2(DEPTH + 1);

   state_e           state_q, state_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d, grant_id;
   tag_t             pipe_q [ACT_LATENCY];
   tag_t             pipe_d [ACT_LATENCY];
   logic             grant_found, credit_ok, issue, pop, fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   id_t              head_id;
   logic [W_OUT-1:0] head_data;
   int unsigned      inflight, idx;
   int               occupancy;

   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      idx         = 0;
      for (int k = 0; k < int'(N_REQ); k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!grant_found && bus_io.req_valid[idx]) begin
            grant_found = 1'b1;
            grant_id    = ID_W'(idx);
         end
      end
   end

   always_comb begin
      inflight = 0;
      for (int k = 0; k < int'(ACT_LATENCY); k++) inflight = inflight + 32'(pipe_q[k].valid);
   end

   // Credit counts the result popped this cycle, so a full pipe keeps streaming.
   assign occupancy = int'(fifo_count) + int'(inflight) - int'(pop);
   assign credit_ok = occupancy < int'(DEPTH);
   assign issue     = (state_q == StRun) && grant_found && credit_ok;

   assign bus_io.req_ready = issue ? (N_REQ'(1) << grant_id) : '0;
   assign act_in_o         = issue ? bus_io.req_data[grant_id*W_IN +: W_IN] : '0;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (issue) rr_ptr_d = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
      pipe_d[0].valid = issue;
      pipe_d[0].id    = id_t'(grant_id);
      for (int k = 1; k < int'(ACT_LATENCY); k++) pipe_d[k] = pipe_q[k-1];
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (enable_i) state_d = StRun;
         StRun:   if (!enable_i) state_d = StDrain;
         StDrain: begin
            if (enable_i)     state_d = StRun;
            else if (!busy_o) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         rr_ptr_q <= '0;
         for (int k = 0; k < int'(ACT_LATENCY); k++) pipe_q[k] <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         for (int k = 0; k < int'(ACT_LATENCY); k++) pipe_q[k] <= pipe_d[k];
      end
   end

   act_result_fifo #(
      .DEPTH (DEPTH),
      .W_OUT (W_OUT),
      .ID_W  (IdMaxW)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (pipe_q[ACT_LATENCY-1].valid),
      .push_id_i   (pipe_q[ACT_LATENCY-1].id),
      .push_data_i (act_out_i),
      .pop_i       (pop),
      .head_id_o   (head_id),
      .head_data_o (head_data),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   assign bus_io.rsp_valid = fifo_empty ? '0 : (N_REQ'(1) << head_id);
   assign bus_io.rsp_data  = fifo_empty ? '0 : head_data;
   assign pop              = |(bus_io.rsp_valid & bus_io.rsp_ready);
   assign busy_o           = (inflight != 0) || (fifo_count != '0);

endmodule
